// File: rtl/exhaustive_stim_gen.sv
// Purpose: sweeps all 64 values of {D,C,B,A} into a combinational unit and captures its F response per vector.
// Latency: each vector is held DWELL unpaused cycles; its capture is presented one cycle after the sample edge.
// Backpressure: hold freezes the dwell counter, vector and capture; start is only honoured in IDLE.
module exhaustive_stim_gen #(
    parameter int DWELL = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    input  logic [2:0] F,
    output logic       A,
    output logic       B,
    output logic [1:0] C,
    output logic [1:0] D,
    output logic       busy,
    output logic       done,
    output logic       cap_valid,
    output logic [5:0] cap_idx,
    output logic [2:0] cap_f
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Dwell counter terminal value; DWELL is limited to 1..255 so 8 bits suffice.
    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);
    localparam logic [5:0] IDX_LAST = 6'd63;

    logic [1:0] state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cap_valid_q, cap_valid_d;
    logic [5:0] cap_idx_q, cap_idx_d;
    logic [2:0] cap_f_q, cap_f_d;

    // The stimulus pins come straight from the index register. idx_q is forced to
    // zero on reset, on sweep start and by the 63->0 wrap that enters DONE, so the
    // pins are already 0 throughout IDLE and DONE without extra gating.
    assign A         = idx_q[0];
    assign B         = idx_q[1];
    assign C         = idx_q[3:2];
    assign D         = idx_q[5:4];
    assign busy      = busy_q;
    assign done      = done_q;
    assign cap_valid = cap_valid_q;
    assign cap_idx   = cap_idx_q;
    assign cap_f     = cap_f_q;

    // Next-state: sweep sequencing, dwell counting and response capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cap_valid_d = 1'b0;
        cap_idx_d   = cap_idx_q;
        cap_f_d     = cap_f_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = 6'd0;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    if (cnt_q == CNT_LAST) begin
                        // F has settled on the current vector for DWELL cycles.
                        cap_valid_d = 1'b1;
                        cap_idx_d   = idx_q;
                        cap_f_d     = F;
                        cnt_d       = 8'd0;
                        idx_d       = idx_q + 6'd1;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 6'd0;
                cnt_d   = 8'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that overrides start and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 6'd0;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= 6'd0;
            cap_f_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cap_valid_q <= cap_valid_d;
            cap_idx_q   <= cap_idx_d;
            cap_f_q     <= cap_f_d;
        end
    end

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Purpose: self-checking bench for exhaustive_stim_gen at DWELL=10 and DWELL=1.
// Latency: expected captures carry the cycle at which they must appear.
// Backpressure: hold is exercised on the DWELL=10 instance; start held high on the DWELL=1 instance.
module tb_exhaustive_stim_gen;

    logic       clk = 1'b0;
    logic       rst;

    logic       start0, hold0;
    logic [2:0] f0;
    logic       a0, b0, busy0, done0, capv0;
    logic [1:0] c0, d0;
    logic [5:0] capidx0;
    logic [2:0] capf0;

    logic       start1, hold1;
    logic [2:0] f1;
    logic       a1, b1, busy1, done1, capv1;
    logic [1:0] c1, d1;
    logic [5:0] capidx1;
    logic [2:0] capf1;

    // Stand-in combinational unit: bit0 is A^B, upper bits pick out C[1] and D[0].
    assign f0 = {d0[0], c0[1], a0 ^ b0};
    assign f1 = {d1[0], c1[1], a1 ^ b1};

    exhaustive_stim_gen #(.DWELL(10)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .hold(hold0), .F(f0),
        .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
        .cap_valid(capv0), .cap_idx(capidx0), .cap_f(capf0)
    );

    exhaustive_stim_gen #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .hold(hold1), .F(f1),
        .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
        .cap_valid(capv1), .cap_idx(capidx1), .cap_f(capf1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] idx;
        logic [2:0] f;
        int         cyc;
    } cap_t;

    cap_t q0[$];
    cap_t q1[$];
    int   dq0[$];
    int   dq1[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] f_of(input logic [5:0] k);
        return {k[4], k[3], k[0] ^ k[1]};
    endfunction

    // Queue the 64 expected captures of a sweep whose first RUN cycle is r.
    task automatic push_sweep(input bit sel, input int r, input int dwell,
                              input int hold_from, input int hold_len, input int n);
        cap_t e;
        for (int k = 0; k < n; k++) begin
            e.idx = 6'(k);
            e.f   = f_of(6'(k));
            e.cyc = r + dwell * (k + 1) + ((k >= hold_from) ? hold_len : 0);
            if (sel) q1.push_back(e);
            else     q0.push_back(e);
        end
    endtask

    // Monitor: every presented capture / done pulse is popped and compared.
    always @(negedge clk) begin : monitor
        cap_t e;
        int   dc;
        if (capv0) begin
            if (q0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL cap0_unexpected: got idx %0d, expected no capture (cycle %0d)", capidx0, cyc);
            end else begin
                e = q0.pop_front();
                chk("cap0_idx", capidx0, e.idx);
                chk("cap0_f", capf0, e.f);
                chk("cap0_cycle", cyc, e.cyc);
            end
        end
        if (done0) begin
            if (dq0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL done0_unexpected: got done, expected none (cycle %0d)", cyc);
            end else begin
                dc = dq0.pop_front();
                chk("done0_cycle", cyc, dc);
            end
        end
        if (capv1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL cap1_unexpected: got idx %0d, expected no capture (cycle %0d)", capidx1, cyc);
            end else begin
                e = q1.pop_front();
                chk("cap1_idx", capidx1, e.idx);
                chk("cap1_f", capf1, e.f);
                chk("cap1_cycle", cyc, e.cyc);
            end
        end
        if (done1) begin
            if (dq1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL done1_unexpected: got done, expected none (cycle %0d)", cyc);
            end else begin
                dc = dq1.pop_front();
                chk("done1_cycle", cyc, dc);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus; all checks sampled at the falling edge.
    initial begin : stim
        int r;
        rst    = 1'b1;
        start0 = 1'b1;
        hold0  = 1'b1;
        start1 = 1'b0;
        hold1  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_vec", {a0, b0, c0, d0}, 6'd0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_capv", capv0, 1'b0);
        chk("rst_capidx", capidx0, 6'd0);
        chk("rst_capf", capf0, 3'd0);
        chk("rst_busy1", busy1, 1'b0);

        rst    = 1'b0;
        start0 = 1'b0;
        hold0  = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy0, 1'b0);

        // Sweep 1: plain DWELL=10 sweep, stray start pulse at RUN cycle 100.
        start0 = 1'b1;
        r = cyc + 1;
        push_sweep(1'b0, r, 10, 64, 0, 64);
        dq0.push_back(r + 640);
        @(negedge clk);
        start0 = 1'b0;
        for (int rel = 0; rel <= 642; rel++) begin
            case (rel)
                0:   begin chk("s1_busy_first", busy0, 1'b1); chk("s1_vec0_early", {a0, b0, c0, d0}, 6'b0_0_00_00); end
                5:   chk("s1_vec0", {a0, b0, c0, d0}, 6'b0_0_00_00);
                15:  begin
                         chk("s1_vec1", {a0, b0, c0, d0}, 6'b1_0_00_00);
                         chk("s1_capidx_hold", capidx0, 6'd0);
                         chk("s1_capf_hold", capf0, 3'b000);
                     end
                25:  chk("s1_vec2", {a0, b0, c0, d0}, 6'b0_1_00_00);
                35:  chk("s1_vec3", {a0, b0, c0, d0}, 6'b1_1_00_00);
                45:  chk("s1_vec4", {a0, b0, c0, d0}, 6'b0_0_01_00);
                100: start0 = 1'b1;
                101: begin start0 = 1'b0; chk("s1_busy_after_start", busy0, 1'b1); end
                635: chk("s1_vec63", {a0, b0, c0, d0}, 6'b1_1_11_11);
                639: chk("s1_busy_last", busy0, 1'b1);
                640: begin chk("s1_busy_done", busy0, 1'b0); chk("s1_vec_done", {a0, b0, c0, d0}, 6'd0); end
                642: chk("s1_busy_idle", busy0, 1'b0);
                default: ;
            endcase
            @(negedge clk);
        end

        // Sweep 2: reset applied at RUN cycle 200 aborts the sweep.
        start0 = 1'b1;
        r = cyc + 1;
        push_sweep(1'b0, r, 10, 64, 0, 20);
        @(negedge clk);
        start0 = 1'b0;
        for (int rel = 0; rel < 200; rel++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_vec", {a0, b0, c0, d0}, 6'd0);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_done", done0, 1'b0);
        chk("abort_capv", capv0, 1'b0);
        chk("abort_capidx", capidx0, 6'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Sweep 3: hold for 7 cycles during vector 5.
        start0 = 1'b1;
        r = cyc + 1;
        push_sweep(1'b0, r, 10, 5, 7, 64);
        dq0.push_back(r + 647);
        @(negedge clk);
        start0 = 1'b0;
        for (int rel = 0; rel <= 650; rel++) begin
            case (rel)
                0:   chk("s3_vec0", {a0, b0, c0, d0}, 6'd0);
                52:  hold0 = 1'b1;
                59:  hold0 = 1'b0;
                66:  chk("s3_vec5_held", {a0, b0, c0, d0}, 6'b1_0_01_00);
                67:  chk("s3_vec6", {a0, b0, c0, d0}, 6'b0_1_01_00);
                646: chk("s3_busy_last", busy0, 1'b1);
                647: chk("s3_busy_done", busy0, 1'b0);
                default: ;
            endcase
            @(negedge clk);
        end

        // Sweep 4: DWELL=1 with start held high gives two back-to-back sweeps.
        start1 = 1'b1;
        r = cyc + 1;
        push_sweep(1'b1, r, 1, 64, 0, 64);
        dq1.push_back(r + 64);
        push_sweep(1'b1, r + 66, 1, 64, 0, 64);
        dq1.push_back(r + 130);
        @(negedge clk);
        for (int rel = 0; rel <= 135; rel++) begin
            case (rel)
                0:   chk("d1_busy_first", busy1, 1'b1);
                5:   chk("d1_vec5", {a1, b1, c1, d1}, 6'b1_0_01_00);
                63:  begin chk("d1_vec63", {a1, b1, c1, d1}, 6'b1_1_11_11); chk("d1_busy_last", busy1, 1'b1); end
                64:  chk("d1_busy_done", busy1, 1'b0);
                65:  chk("d1_busy_idle", busy1, 1'b0);
                66:  chk("d1_busy_restart", busy1, 1'b1);
                70:  start1 = 1'b0;
                130: chk("d1_busy_done2", busy1, 1'b0);
                135: chk("d1_busy_stay_idle", busy1, 1'b0);
                default: ;
            endcase
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("dq0_drained", dq0.size(), 0);
        chk("dq1_drained", dq1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
